// File: rtl/wavegen_pkg.sv
// Shared mode encoding and full-scale helpers for the multi-channel waveform generator.
package wavegen_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    SAW   = 2'b01,
    PULSE = 2'b10,
    TRI   = 2'b11
  } wave_mode_t;

  // Largest positive two's complement value for a w-bit sample
  function automatic int fs_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative two's complement value for a w-bit sample
  function automatic int fs_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/wave_channel.sv
// One generator channel: phase accumulator, shadow/active config with deferred apply, shaper.
module wave_channel
  import wavegen_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  wave_mode_t       wr_mode_i,
  input  logic [N-1:0]     wr_freq_i,
  input  logic [N-1:0]     wr_duty_i,
  input  logic [N-1:0]     wr_phase_i,
  input  logic             wr_imm_i,
  output logic             pending_o,
  output logic [M-1:0]     sample_o,
  output logic             wrap_o
);

  typedef struct packed {
    wave_mode_t   mode;
    logic [N-1:0] freq;
    logic [N-1:0] duty;
    logic [N-1:0] phase;
  } cfg_t;

  logic [N-1:0] acc_q,     acc_d;
  cfg_t         active_q,  active_d;
  cfg_t         shadow_q,  shadow_d;
  logic         pending_q, pending_d;
  logic         imm_q,     imm_d;
  logic         carry_q,   carry_d;
  logic [M-1:0] sample_q,  sample_d;
  logic         wrap_q,    wrap_d;

  logic         apply_c;
  logic [N:0]   sum_c;

  function automatic logic [M-1:0] shape(input logic [N-1:0] acc, input cfg_t cfg);
    logic [M-1:0] t;
    logic [M-1:0] u;
    t = acc[N-1 -: M];
    // Triangle folds the upper half of the phase back down so the MSB crossing is continuous
    u = acc[N-2 -: M];
    if (acc[N-1]) u = ~u;
    case (cfg.mode)
      SAW:     return {~t[M-1], t[M-2:0]};
      PULSE:   return (acc < cfg.duty) ? M'(fs_max(M)) : M'(fs_min(M));
      TRI:     return {~u[M-1], u[M-2:0]};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    acc_d     = acc_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    imm_d     = imm_q;
    carry_d   = 1'b0;

    sum_c   = {1'b0, acc_q} + {1'b0, active_q.freq};
    apply_c = pending_q & (carry_q | imm_q | ~en_i);

    if (apply_c) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      imm_d     = 1'b0;
    end

    if (wr_i) begin
      shadow_d  = '{mode: wr_mode_i, freq: wr_freq_i, duty: wr_duty_i, phase: wr_phase_i};
      pending_d = 1'b1;
      imm_d     = wr_imm_i;
    end

    // Sync reload uses the freshly applied phase and suppresses the increment and carry
    if (sync_i) begin
      acc_d = active_d.phase;
    end else if (en_i) begin
      acc_d   = sum_c[N-1:0];
      carry_d = sum_c[N];
    end

    sample_d = en_i ? shape(acc_q, active_q) : '0;
    wrap_d   = en_i & carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      imm_q     <= 1'b0;
      carry_q   <= 1'b0;
      sample_q  <= '0;
      wrap_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      imm_q     <= imm_d;
      carry_q   <= carry_d;
      sample_q  <= sample_d;
      wrap_q    <= wrap_d;
    end
  end

  assign pending_o = pending_q;
  assign sample_o  = sample_q;
  assign wrap_o    = wrap_q;

endmodule

// File: rtl/multi_wave_gen.sv
// CH-channel waveform generator: config decode, ready mux and packing of per-channel samples.
module multi_wave_gen
  import wavegen_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned M  = 16,
  parameter int unsigned CH = 4,
  parameter int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   ch_en,
  input  logic            sync_in,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [N-1:0]    cfg_freq,
  input  logic [N-1:0]    cfg_duty,
  input  logic [N-1:0]    cfg_phase,
  input  logic            cfg_immediate,
  output logic [CH*M-1:0] wave_out,
  output logic [CH-1:0]   wrap_out
);

  localparam int unsigned PADW = 1 << CW;

  logic [CH-1:0]   pend_vec;
  logic [PADW-1:0] pend_pad;
  logic            accept_c;

  // Indices beyond CH read as never-pending so such writes are accepted and dropped
  always_comb begin
    pend_pad           = '0;
    pend_pad[CH-1:0]   = pend_vec;
  end

  assign cfg_ready = ~pend_pad[cfg_ch];
  assign accept_c  = cfg_valid & cfg_ready;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    wave_channel #(
      .N (N),
      .M (M)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst),
      .en_i       (ch_en[c]),
      .sync_i     (sync_in),
      .wr_i       (accept_c && (cfg_ch == CW'(c))),
      .wr_mode_i  (wave_mode_t'(cfg_mode)),
      .wr_freq_i  (cfg_freq),
      .wr_duty_i  (cfg_duty),
      .wr_phase_i (cfg_phase),
      .wr_imm_i   (cfg_immediate),
      .pending_o  (pend_vec[c]),
      .sample_o   (wave_out[c*M +: M]),
      .wrap_o     (wrap_out[c])
    );
  end

endmodule

// File: tb/tb_multi_wave_gen.sv
// Directed and randomized checks of multi_wave_gen (N=16, M=8, CH=2) against an arithmetic reference model.
module tb_multi_wave_gen;

  localparam int unsigned N  = 16;
  localparam int unsigned M  = 8;
  localparam int unsigned CH = 2;
  localparam int unsigned CW = 1;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   ch_en;
  logic            sync_in;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_ch;
  logic [1:0]      cfg_mode;
  logic [N-1:0]    cfg_freq;
  logic [N-1:0]    cfg_duty;
  logic [N-1:0]    cfg_phase;
  logic            cfg_immediate;
  logic [CH*M-1:0] wave_out;
  logic [CH-1:0]   wrap_out;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: active and shadow configs, accumulator, pending bookkeeping
  int m_acc   [CH];
  int m_mode  [CH];
  int m_freq  [CH];
  int m_duty  [CH];
  int m_phase [CH];
  int s_mode  [CH];
  int s_freq  [CH];
  int s_duty  [CH];
  int s_phase [CH];
  bit m_pend  [CH];
  bit m_imm   [CH];
  bit m_carry [CH];
  int e_wave  [CH];
  bit e_wrap  [CH];

  multi_wave_gen #(.N(N), .M(M), .CH(CH), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_en         (ch_en),
    .sync_in       (sync_in),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_mode      (cfg_mode),
    .cfg_freq      (cfg_freq),
    .cfg_duty      (cfg_duty),
    .cfg_phase     (cfg_phase),
    .cfg_immediate (cfg_immediate),
    .wave_out      (wave_out),
    .wrap_out      (wrap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wave(input int c);
    logic signed [M-1:0] s;
    s = wave_out[c*M +: M];
    return int'(s);
  endfunction

  // Waveform value from the phase using plain arithmetic on a 16-bit phase, 8-bit sample
  function automatic int shape_ref(input int mode, input int acc, input int duty);
    int ph;
    case (mode)
      1: return acc / 256 - 128;
      2: return (acc < duty) ? 127 : -128;
      3: begin
        ph = acc / 128;
        return (ph < 256) ? ph - 128 : 383 - ph;
      end
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_mode[c] = 0; m_freq[c] = 0; m_duty[c] = 0; m_phase[c] = 0;
      s_mode[c] = 0; s_freq[c] = 0; s_duty[c] = 0; s_phase[c] = 0;
      m_pend[c] = 1'b0; m_imm[c] = 1'b0; m_carry[c] = 1'b0;
      e_wave[c] = 0; e_wrap[c] = 1'b0;
    end
  endfunction

  // Advance the model by one rising edge using the inputs currently driven
  function automatic void model_edge();
    bit take;
    int tgt;
    int old_freq;
    int sum;
    tgt  = int'(cfg_ch);
    take = cfg_valid && (tgt >= CH || !m_pend[tgt]);
    for (int c = 0; c < CH; c++) begin
      e_wave[c] = ch_en[c] ? shape_ref(m_mode[c], m_acc[c], m_duty[c]) : 0;
      e_wrap[c] = ch_en[c] && m_carry[c];
      old_freq  = m_freq[c];
      if (m_pend[c] && (m_carry[c] || m_imm[c] || !ch_en[c])) begin
        m_mode[c] = s_mode[c]; m_freq[c] = s_freq[c];
        m_duty[c] = s_duty[c]; m_phase[c] = s_phase[c];
        m_pend[c] = 1'b0; m_imm[c] = 1'b0;
      end
      if (sync_in) begin
        m_acc[c]   = m_phase[c];
        m_carry[c] = 1'b0;
      end else if (ch_en[c]) begin
        sum        = m_acc[c] + old_freq;
        m_carry[c] = (sum >= 65536);
        m_acc[c]   = sum % 65536;
      end else begin
        m_carry[c] = 1'b0;
      end
    end
    if (take && tgt < CH) begin
      s_mode[tgt] = int'(cfg_mode); s_freq[tgt] = int'(cfg_freq);
      s_duty[tgt] = int'(cfg_duty); s_phase[tgt] = int'(cfg_phase);
      m_pend[tgt] = 1'b1; m_imm[tgt] = cfg_immediate;
    end
  endfunction

  task automatic step();
    #1;
    check("cfg_ready", int'(cfg_ready), (int'(cfg_ch) >= CH) ? 1 : int'(!m_pend[cfg_ch]));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("wave%0d", c), wave(c), e_wave[c]);
      check($sformatf("wrap%0d", c), int'(wrap_out[c]), int'(e_wrap[c]));
    end
  endtask

  task automatic write_cfg(input int ch, input int mode, input int freq, input int duty,
                           input int phase, input bit imm);
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_mode = 2'(mode);
    cfg_freq = 16'(freq); cfg_duty = 16'(duty); cfg_phase = 16'(phase); cfg_immediate = imm;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic sync_pulse();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b0; ch_en = '0; sync_in = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_mode = '0; cfg_freq = '0; cfg_duty = '0; cfg_phase = '0; cfg_immediate = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_wave", int'(wave_out), 0);
    check("rst_wrap", int'(wrap_out), 0);
    check("rst_ready", int'(cfg_ready), 1);
    rst = 1'b1;

    // Sawtooth on ch0, ch1 idle
    ch_en = 2'b01;
    write_cfg(0, 1, 16'h1000, 0, 0, 1'b1);
    step();
    for (int i = 0; i < 34; i++) begin
      step();
      check("saw_seq", wave(0), -128 + 16 * (i % 16));
      check("saw_wrap", int'(wrap_out[0]), (i % 16 == 0 && i > 0) ? 1 : 0);
      check("ch1_idle", wave(1), 0);
    end

    // Pulse, 50% duty then duty 0
    write_cfg(0, 2, 16'h1000, 16'h8000, 0, 1'b1);
    step();
    sync_pulse();
    for (int i = 0; i < 32; i++) begin
      step();
      check("pulse_seq", wave(0), ((i % 16) < 8) ? 127 : -128);
    end
    write_cfg(0, 2, 16'h1000, 0, 0, 1'b1);
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("pulse_duty0", wave(0), -128);
    end

    // Triangle on ch1
    ch_en = 2'b11;
    write_cfg(1, 3, 16'h0800, 0, 0, 1'b1);
    step();
    sync_pulse();
    for (int i = 0; i < 64; i++) begin
      step();
      p = i % 32;
      check("tri_seq", wave(1), (p < 16) ? -128 + 16 * p : 127 - 16 * (p - 16));
    end

    // Deferred frequency change on ch0 with a stalled second write
    write_cfg(0, 1, 16'h1000, 0, 0, 1'b1);
    step();
    sync_pulse();
    for (int i = 0; i < 5; i++) begin
      step();
      check("defer_pre", wave(0), -128 + 16 * i);
    end
    cfg_valid = 1'b1; cfg_ch = '0; cfg_mode = 2'd1; cfg_freq = 16'h2000; cfg_immediate = 1'b0;
    step();
    check("defer_accept", wave(0), -48);
    cfg_freq = 16'h4000;
    for (int i = 6; i < 16; i++) begin
      step();
      check("defer_stall_ready", int'(cfg_ready), 0);
      check("defer_old_step", wave(0), -128 + 16 * i);
    end
    cfg_valid = 1'b0;
    step();
    check("defer_wrap_sample", wave(0), -128);
    check("defer_wrap", int'(wrap_out[0]), 1);
    check("defer_ready_back", int'(cfg_ready), 1);
    step();
    check("defer_new0", wave(0), -112);
    step();
    check("defer_new1", wave(0), -80);
    step();
    check("defer_new2", wave(0), -48);

    // Phase-offset sync between the two channels
    write_cfg(0, 1, 16'h1000, 0, 0, 1'b1);
    write_cfg(1, 1, 16'h1000, 0, 16'h8000, 1'b1);
    step();
    sync_pulse();
    for (int i = 0; i < 24; i++) begin
      step();
      check("sync_ch0", wave(0), -128 + 16 * (i % 16));
      check("sync_ch1", wave(1), -128 + 16 * ((i + 8) % 16));
    end

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      ch_en         = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
      sync_in       = ($urandom_range(0, 29) == 0);
      cfg_valid     = ($urandom_range(0, 3) == 0);
      cfg_ch        = CW'($urandom);
      cfg_mode      = 2'($urandom);
      cfg_freq      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1fff));
      cfg_duty      = 16'($urandom);
      cfg_phase     = 16'($urandom);
      cfg_immediate = ($urandom_range(0, 2) == 0);
      step();
    end
    cfg_valid = 1'b0; sync_in = 1'b0; ch_en = '0;
    step();
    step();

    // Asynchronous reset with a write pending
    ch_en = 2'b11;
    write_cfg(0, 1, 16'h1000, 0, 0, 1'b1);
    step();
    sync_pulse();
    repeat (3) step();
    write_cfg(0, 3, 16'h0100, 0, 0, 1'b0);
    cfg_ch = '0;
    #1;
    check("pend_before_rst", int'(cfg_ready), 0);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_wave", int'(wave_out), 0);
    check("async_rst_wrap", int'(wrap_out), 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("hold_rst_wave", int'(wave_out), 0);
    rst = 1'b1;
    ch_en = 2'b01;
    #1;
    check("post_rst_ready", int'(cfg_ready), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_off", wave(0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
